// File: rtl/alu_pkg.sv
// Shared types for the 4-bit CPU datapath: opcodes, issue FSM states,
// instruction field positions, flag bit indices and opcode decode helpers.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'b0000,
    OP_ADD = 4'b0001,
    OP_MUL = 4'b0010,
    OP_CMP = 4'b0011,
    OP_RSH = 4'b0100,
    OP_LSH = 4'b0101,
    OP_LDI = 4'b1000
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  localparam int OP_MSB      = 15;
  localparam int OP_LSB      = 12;
  localparam int RD_MSB      = 11;
  localparam int RD_LSB      = 10;
  localparam int RA_MSB      = 9;
  localparam int RA_LSB      = 8;
  localparam int RB_MSB      = 7;
  localparam int RB_LSB      = 6;
  localparam int USE_IMM_BIT = 5;
  localparam int RSVD_BIT    = 4;
  localparam int IMM_MSB     = 3;
  localparam int IMM_LSB     = 0;

  localparam int FL_C = 0;
  localparam int FL_V = 1;
  localparam int FL_N = 2;
  localparam int FL_Z = 3;

  function automatic logic is_legal(input logic [3:0] op);
    case (op)
      OP_NOP, OP_ADD, OP_MUL, OP_CMP, OP_RSH, OP_LSH, OP_LDI: is_legal = 1'b1;
      default:                                                is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic writes_reg(input logic [3:0] op);
    case (op)
      OP_ADD, OP_MUL, OP_RSH, OP_LSH, OP_LDI: writes_reg = 1'b1;
      default:                                writes_reg = 1'b0;
    endcase
  endfunction

  function automatic logic writes_flags(input logic [3:0] op);
    case (op)
      OP_ADD, OP_MUL, OP_CMP: writes_flags = 1'b1;
      default:                writes_flags = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/regfile_4x4.sv
// Small register file: async-reset storage, one synchronous write port and
// three combinational read ports (two operands plus debug).
module regfile_4x4 #(
  parameter int DW   = 4,
  parameter int NREG = 4,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] ra_addr,
  output logic [DW-1:0] ra_data,
  input  logic [AW-1:0] rb_addr,
  output logic [DW-1:0] rb_data,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  logic [DW-1:0] mem [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign ra_data  = mem[ra_addr];
  assign rb_data  = mem[rb_addr];
  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback sequencer in front of the 4-bit ALU (IDLE->EXEC->WB).
// Optional sticky illegal-opcode trap enabled by defining ILLEGAL_TRAP_EN.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int         DW        = 4,
  parameter int         NREG      = 4,
  parameter logic [3:0] FLAGS_RST = 4'h0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [15:0]   instr,
  output logic [3:0]    alu_opcode,
  output logic [DW-1:0] alu_op1,
  output logic [DW-1:0] alu_op2,
  input  logic [DW-1:0] alu_dout,
  input  logic [3:0]    alu_eflags,
  output logic [3:0]    flags,
  output logic          done,
`ifdef ILLEGAL_TRAP_EN
  output logic          trap,
`endif
  input  logic [1:0]    dbg_addr,
  output logic [DW-1:0] dbg_data
);

  localparam int AW = $clog2(NREG);

  state_e        state_q, state_d;
  logic          accept;
  logic          rf_we, flags_we;
  logic [DW-1:0] rf_wdata;
  logic [DW-1:0] ra_data, rb_data;
  logic [AW-1:0] rd_q;
  logic [DW-1:0] imm_q;
  logic          trap_q;
  logic          unused_rsvd;

  assign unused_rsvd = instr[RSVD_BIT];
  assign accept      = instr_valid & instr_ready;

  regfile_4x4 #(.DW(DW), .NREG(NREG), .AW(AW)) u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (rf_we),
    .waddr   (rd_q),
    .wdata   (rf_wdata),
    .ra_addr (instr[RA_MSB:RA_LSB]),
    .ra_data (ra_data),
    .rb_addr (instr[RB_MSB:RB_LSB]),
    .rb_data (rb_data),
    .dbg_addr(dbg_addr),
    .dbg_data(dbg_data)
  );

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    done        = 1'b0;
    rf_we       = 1'b0;
    flags_we    = 1'b0;
    rf_wdata    = alu_dout;
    case (state_q)
      ST_IDLE: begin
        instr_ready = ~trap_q;
        if (instr_valid && !trap_q) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        // The ALU result is valid by the end of EXEC; LDI bypasses it.
        rf_we    = writes_reg(alu_opcode);
        flags_we = writes_flags(alu_opcode);
        if (alu_opcode == OP_LDI) rf_wdata = imm_q;
        state_d  = ST_WB;
      end
      ST_WB: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // p0: accept stage -> registered ALU drive, FSM and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      flags      <= FLAGS_RST;
      alu_opcode <= '0;
      alu_op1    <= '0;
      alu_op2    <= '0;
    end else begin
      state_q <= state_d;
      if (flags_we) flags <= alu_eflags;
      if (accept) begin
        alu_opcode <= instr[OP_MSB:OP_LSB];
        alu_op1    <= ra_data;
        alu_op2    <= instr[USE_IMM_BIT] ? DW'(instr[IMM_MSB:IMM_LSB]) : rb_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      rd_q  <= instr[RD_MSB:RD_LSB];
      imm_q <= DW'(instr[IMM_MSB:IMM_LSB]);
    end
  end

`ifdef ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          trap_q <= 1'b0;
    else if (state_q == ST_EXEC && !is_legal(alu_opcode)) trap_q <= 1'b1;
  end
  assign trap = trap_q;
`else
  assign trap_q = 1'b0;
`endif

endmodule
